csa_multicycle_add_ctrl: RTL and testbench
==========================================

Name: csa_multicycle_add_ctrl

Overview:
- Sequential wide adder controller. Computes one WIDTH-bit add over WIDTH/SLICE cycles by reusing a single SLICE-bit carry-select slice.
- The carry between slices is held in a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area compared with a full-width carry-select adder.

Parameters:
- WIDTH, 32, operand/sum width; must be an integer multiple of SLICE.
- SLICE, 4, slice width processed per cycle (2..8).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set a/b/c_in is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + c_in, low WIDTH bits.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow of the completed add.
- busy  output  1  high while in ADD or DONE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset overrides every other input in the same edge.
- Reset values: state=IDLE, slice index=0, carry reg=0, sum=0, c_out=0, ovf=0, out_valid=0, busy=0. in_ready=1 after the reset edge.
- Slice count: N = WIDTH/SLICE.
- Slice index: log2-sized counter, range 0..N-1.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1 (decoded from state, no input dependency).
  - On in_valid at an edge: latch a, b; carry reg <= c_in; index <= 0; clear sum reg; go to ADD.
- ADD:
  - Slice datapath is carry-select: two SLICE-bit ripple chains on a[idx*SLICE +: SLICE] and b[...], with carry-in forced to 0 and to 1 respectively.
  - A 2:1 mux selected by the carry reg picks {carry, sum bits}.
  - Each edge: write the selected sum bits into sum[idx*SLICE +: SLICE]; carry reg <= selected carry; index <= index+1.
  - When index==N-1: go to DONE, set out_valid=1, c_out <= selected carry, ovf <= (a_lat[W-1]==b_lat[W-1]) && (new sum MSB != a_lat[W-1]).
- DONE:
  - out_valid=1. sum, c_out and ovf are held stable.
  - On out_ready at an edge: go to IDLE, out_valid <= 0. sum, c_out and ovf keep their value until the next accept clears sum.
- Latency: with acceptance at edge k, out_valid is high after edge k+N.
  - Minimum issue interval is N+2 cycles (DONE handshake edge, then IDLE accept edge).
- Boundary conditions:
  - in_valid outside IDLE is ignored; operands are not latched and no error is raised.
  - Input a/b/c_in changing during ADD has no effect; latched copies are used.
  - out_ready while not in DONE is ignored.
  - out_ready held low: stay in DONE indefinitely with outputs stable.
  - reset during ADD or DONE: abort. Next cycle shows reset values; the partial result is discarded.
  - N==1 (WIDTH==SLICE): ADD lasts one edge; otherwise identical.
  - Full carry propagation (all-ones + c_in=1): carry ripples through the carry reg one slice per cycle; latency does not change.
- Arithmetic: unsigned modulo 2^WIDTH. c_out is the true unsigned carry. ovf is the two's-complement overflow.

Test Plan (WIDTH=32, SLICE=4, N=8):
1. a=0x00000001, b=0x00000002, c_in=0, out_ready=1 -> out_valid rises 8 edges after accept; sum=0x00000003, c_out=0, ovf=0; in_ready low from accept until return to IDLE.
2. a=0xFFFFFFFF, b=0x00000000, c_in=1 -> sum=0x00000000, c_out=1, ovf=0; latency still 8 edges.
3. a=0x7FFFFFFF, b=0x00000001, c_in=0 -> sum=0x80000000, c_out=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0, c_out=1, ovf=1.
4. Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
   - Result is stable, in_ready=0, new operands are not taken.
   - out_ready=1 -> IDLE on that edge; new operands accepted on the following edge.
5. reset=1 for one edge while index==3 in ADD -> next cycle out_valid=0, busy=0, sum=0, in_ready=1. A following add of 0x12345678+0x11111111 gives 0x23456789, c_out=0.
6. Back-to-back: in_valid and out_ready held high with 0xA5A5A5A5+0x5A5A5A5A (c_in=0, then c_in=1).
   - Results 0xFFFFFFFF/c_out=0, then 0x00000000/c_out=1.
   - Accept edges are exactly 10 cycles apart.

Source files
------------

// File: rtl/csa_multicycle_add_ctrl_if.sv
// ============================================================================
// csa_multicycle_add_ctrl_if : operand/result handshake bundle for the
//                              multi-cycle carry-select adder controller
// Revision : 1.0
// ============================================================================
`default_nettype none

interface csa_multicycle_add_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/csa_multicycle_add_ctrl.sv
// ============================================================================
// csa_multicycle_add_ctrl : WIDTH-bit add computed over WIDTH/SLICE cycles
//                           by one reused SLICE-bit carry-select slice
// Revision : 1.0
// ============================================================================
`default_nettype none

module csa_multicycle_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  csa_multicycle_add_ctrl_if.slave   bus
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int BW   = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             c_out_r;
  logic             ovf_r;

  logic [BW-1:0]    base;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   res0;
  logic [SLICE:0]   res1;
  logic [SLICE:0]   sel;
  logic             last;

  // Both carry-in outcomes are formed up front; the registered carry only picks one.
  assign base = BW'(idx) * BW'(SLICE);
  assign a_sl = a_lat[base +: SLICE];
  assign b_sl = b_lat[base +: SLICE];
  assign res0 = {1'b0, a_sl} + {1'b0, b_sl};
  assign res1 = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(1);
  assign sel  = carry ? res1 : res0;
  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ADD;
      end
      ADD: begin
        bus.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_lat <= bus.a;
            b_lat <= bus.b;
            carry <= bus.c_in;
            idx   <= '0;
            sum_r <= '0;
          end
        end
        ADD: begin
          sum_r[base +: SLICE] <= sel[SLICE-1:0];
          carry                <= sel[SLICE];
          if (last) begin
            idx     <= '0;
            c_out_r <= sel[SLICE];
            // Final slice supplies the new sum MSB directly.
            ovf_r   <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) &&
                       (sel[SLICE-1] != a_lat[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;

endmodule

`default_nettype wire

// File: tb/tb_csa_multicycle_add_ctrl.sv
// ============================================================================
// tb_csa_multicycle_add_ctrl : directed bench for csa_multicycle_add_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csa_multicycle_add_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;
  int   n;
  int   t1;
  int   t2;
  logic [31:0] held;

  csa_multicycle_add_ctrl_if #(.WIDTH(32)) ifc ();

  csa_multicycle_add_ctrl #(.WIDTH(32), .SLICE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands while idle and step past the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci);
    ifc.a        = a;
    ifc.b        = b;
    ifc.c_in     = ci;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.a        = ~a;
    ifc.b        = ~b;
    ifc.c_in     = ~ci;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (ifc.out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] s,
                              input logic co, input logic ov);
    chk({tag, "_sum"}, 64'(ifc.sum), 64'(s));
    chk({tag, "_cout"}, 64'(ifc.c_out), 64'(co));
    chk({tag, "_ovf"}, 64'(ifc.ovf), 64'(ov));
  endtask

  task automatic release_result();
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    reset = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.c_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    check_result("rst", 32'h0, 1'b0, 1'b0);

    // 1: simple add, latency and in_ready
    issue(32'h0000_0001, 32'h0000_0002, 1'b0);
    chk("t1_in_ready_low", 64'(ifc.in_ready), 64'd0);
    chk("t1_busy", 64'(ifc.busy), 64'd1);
    wait_valid(n);
    chk("t1_latency", 64'(n), 64'd8);
    check_result("t1", 32'h0000_0003, 1'b0, 1'b0);
    release_result();
    chk("t1_back_idle", 64'(ifc.in_ready), 64'd1);
    chk("t1_ov_low", 64'(ifc.out_valid), 64'd0);

    // 2: full carry propagation
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_valid(n);
    chk("t2_latency", 64'(n), 64'd8);
    check_result("t2", 32'h0000_0000, 1'b1, 1'b0);
    release_result();

    // 3: signed overflow both directions
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_valid(n);
    check_result("t3a", 32'h8000_0000, 1'b0, 1'b1);
    release_result();
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_valid(n);
    check_result("t3b", 32'h0000_0000, 1'b1, 1'b1);
    release_result();

    // 4: backpressure with competing operands
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    wait_valid(n);
    check_result("t4a", 32'h0001_0000, 1'b0, 1'b0);
    ifc.a = 32'h1111_1111;
    ifc.b = 32'h2222_2222;
    ifc.c_in = 1'b1;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      held = ifc.sum;
      chk("t4_hold_sum", 64'(held), 64'h0001_0000);
      chk("t4_hold_valid", 64'(ifc.out_valid), 64'd1);
      chk("t4_hold_in_ready", 64'(ifc.in_ready), 64'd0);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk("t4_idle_in_ready", 64'(ifc.in_ready), 64'd1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("t4_new_accept", 64'(ifc.busy), 64'd1);
    wait_valid(n);
    chk("t4_latency", 64'(n), 64'd8);
    check_result("t4b", 32'h3333_3334, 1'b0, 1'b0);
    release_result();

    // 5: abort mid-add
    issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("t5_busy", 64'(ifc.busy), 64'd0);
    chk("t5_in_ready", 64'(ifc.in_ready), 64'd1);
    check_result("t5_rst", 32'h0, 1'b0, 1'b0);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_valid(n);
    check_result("t5", 32'h2345_6789, 1'b0, 1'b0);
    release_result();

    // 6: back-to-back with both handshakes held high
    ifc.a = 32'hA5A5_A5A5;
    ifc.b = 32'h5A5A_5A5A;
    ifc.c_in = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    t1 = cyc;
    chk("t6_accept1", 64'(ifc.busy), 64'd1);
    ifc.c_in = 1'b1;
    wait_valid(n);
    chk("t6_latency1", 64'(n), 64'd8);
    check_result("t6a", 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_idle", 64'(ifc.in_ready), 64'd1);
    @(negedge clk);
    t2 = cyc;
    ifc.in_valid = 1'b0;
    chk("t6_accept2", 64'(ifc.busy), 64'd1);
    chk("t6_interval", 64'(t2 - t1), 64'd10);
    wait_valid(n);
    check_result("t6b", 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk("t6_end_idle", 64'(ifc.in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
